// File: rtl/riscv_pkg.sv
// Shared pipeline constants and the fetch FSM state encoding.
//   XLEN      : default PC / address width
//   RESET_PC  : default PC loaded on reset (word aligned)
//   NOP_INSTR : addi x0,x0,0, placed in pipeline registers when empty/flushed
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // REQ : free to issue a fetch
    // WAIT: one request outstanding, its response is wanted
    // KILL: one request outstanding, its response belongs to a dead path
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages (used for IF/ID, reusable for ID/EX).
// Priority: flush > load > hold. A stalled load is a hold.
//   clk, rst_n       : clock, asynchronous active-low reset
//   load             : capture in_pc/in_instr as a valid entry
//   stall            : suppress load, keep contents
//   flush            : invalidate, instr <= NOP, pc unchanged
//   in_pc, in_instr  : incoming entry
//   valid, pc, instr : registered entry
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int          XLEN = riscv_pkg::XLEN,
    parameter logic [31:0] NOP  = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (load && !stall) begin
            valid <= 1'b1;
            pc    <= in_pc;
            instr <= in_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, one-entry
// hold buffer for responses that arrive during a stall, and the IF/ID register.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   stall_if, flush_if_id           : from hazard unit
//   redirect_valid, redirect_pc     : taken branch/jump from EX
//   imem_req_valid/ready/addr       : fetch request channel
//   imem_rsp_valid/data             : fetch response (one per accepted request)
//   id_valid, id_pc, id_instr       : IF/ID register contents
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_if,
    input  logic            flush_if_id,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_instr;

    logic            hs;
    logic            rsp_take;
    logic            id_load;
    logic [XLEN-1:0] redirect_tgt;

    // rst_n gating keeps the request low during reset even though the
    // reset state is REQ with an empty buffer.
    assign imem_req_valid = rst_n && (state == ST_REQ) && !buf_valid;
    assign imem_req_addr  = pc;
    assign hs             = imem_req_valid && imem_req_ready;
    assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};

    // A response that coincides with a redirect is wrong-path and is dropped.
    assign rsp_take = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    // The buffer is only ever full while no request is outstanding, so the
    // two IF/ID sources are mutually exclusive.
    assign id_load  = !redirect_valid && (buf_valid || rsp_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_REQ;
            pc        <= XLEN'(RESET_PC);
            req_pc    <= '0;
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            pc        <= redirect_tgt;
            buf_valid <= 1'b0;
            case (state)
                ST_REQ:  if (hs) state <= ST_KILL;
                ST_WAIT: state <= imem_rsp_valid ? ST_REQ : ST_KILL;
                // A response landing in the redirect cycle retires the only
                // outstanding request; staying in KILL would then wait forever.
                ST_KILL: state <= imem_rsp_valid ? ST_REQ : ST_KILL;
                default: state <= ST_REQ;
            endcase
        end else begin
            if (buf_valid && !stall_if)
                buf_valid <= 1'b0;
            case (state)
                ST_REQ: begin
                    if (hs) begin
                        req_pc <= pc;
                        pc     <= pc + XLEN'(4);
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= ST_REQ;
                        if (stall_if) begin
                            buf_valid <= 1'b1;
                            buf_pc    <= req_pc;
                            buf_instr <= imem_rsp_data;
                        end
                    end
                end
                ST_KILL: if (imem_rsp_valid) state <= ST_REQ;
                default: state <= ST_REQ;
            endcase
        end
    end

    if_id_reg #(.XLEN(XLEN), .NOP(NOP_INSTR)) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (id_load),
        .stall    (stall_if),
        .flush    (flush_if_id),
        .in_pc    (buf_valid ? buf_pc : req_pc),
        .in_instr (buf_valid ? buf_instr : imem_rsp_data),
        .valid    (id_valid),
        .pc       (id_pc),
        .instr    (id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A small memory model answers each accepted
// request with data == address after `lat` cycles. The main sequence acts
// 1 time unit after each falling edge; the memory samples the handshake
// 2 units after the falling edge so it sees the inputs driven there.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_if, flush_if_id, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_if       (stall_if),
        .flush_if_id    (flush_if_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    int          lat = 1;
    int          cnt = 0;
    logic        hs_cap = 1'b0;
    logic [31:0] addr_cap = '0;
    logic [31:0] paddr = '0;

    initial forever begin
        @(negedge clk);
        #2;
        hs_cap   = rst_n && imem_req_valid && imem_req_ready;
        addr_cap = imem_req_addr;
    end

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (hs_cap) begin
                    cnt   = lat;
                    paddr = addr_cap;
                end
                if (cnt > 0) begin
                    if (cnt == 1) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = paddr;
                    end
                    cnt--;
                end
            end
            hs_cap = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] i);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(v));
        chk({tag, ".id_pc"}, id_pc, p);
        chk({tag, ".id_instr"}, id_instr, i);
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
        chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(v));
        chk({tag, ".req_addr"}, imem_req_addr, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks so far %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n          = 1'b0;
        stall_if       = 1'b0;
        flush_if_id    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;

        step();
        chk_req("reset", 1'b0, 32'h0);
        chk_id("reset", 1'b0, 32'h0, 32'h13);

        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: basic fetch, 1-cycle memory
        step();                                   // N0
        chk_req("t1.n0", 1'b1, 32'h0);
        chk_id("t1.n0", 1'b0, 32'h0, 32'h13);
        step();                                   // N1: WAIT
        chk_req("t1.n1", 1'b0, 32'h4);
        chk_id("t1.n1", 1'b0, 32'h0, 32'h13);
        step();                                   // N2
        chk_id("t1.n2", 1'b1, 32'h0, 32'h0);
        chk_req("t1.n2", 1'b1, 32'h4);
        step();                                   // N3
        step();                                   // N4
        chk_id("t1.n4", 1'b1, 32'h4, 32'h4);
        chk_req("t1.n4", 1'b1, 32'h8);

        // 2: stall while the response for 0x8 arrives
        step();                                   // N5: WAIT on 0x8
        stall_if = 1'b1;
        step();                                   // N6: buffered
        chk_req("t2.n6", 1'b0, 32'hC);
        chk_id("t2.n6", 1'b1, 32'h4, 32'h4);
        step();                                   // N7
        chk_req("t2.n7", 1'b0, 32'hC);
        step();                                   // N8
        chk_id("t2.n8", 1'b1, 32'h4, 32'h4);
        stall_if = 1'b0;
        step();                                   // N9: drained
        chk_id("t2.n9", 1'b1, 32'h8, 32'h8);
        chk_req("t2.n9", 1'b1, 32'hC);
        step();                                   // N10
        chk_id("t2.n10", 1'b1, 32'h8, 32'h8);
        step();                                   // N11
        chk_id("t2.n11", 1'b1, 32'hC, 32'hC);
        chk_req("t2.n11", 1'b1, 32'h10);

        // 3: redirect while WAIT, 2-cycle memory so the response lands in KILL
        lat = 2;
        step();                                   // N12: WAIT on 0x10
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();                                   // N13: KILL
        redirect_valid = 1'b0;
        chk_req("t3.n13", 1'b0, 32'h100);
        step();                                   // N14: back in REQ
        chk_req("t3.n14", 1'b1, 32'h100);
        chk_id("t3.n14", 1'b1, 32'hC, 32'hC);
        step();                                   // N15
        step();                                   // N16
        chk_id("t3.n16", 1'b1, 32'hC, 32'hC);
        step();                                   // N17
        chk_id("t3.n17", 1'b1, 32'h100, 32'h100);
        chk_req("t3.n17", 1'b1, 32'h104);
        lat = 1;

        // 4: flush + stall together, response for 0x104 goes to buffer
        step();                                   // N18: WAIT on 0x104
        stall_if    = 1'b1;
        flush_if_id = 1'b1;
        step();                                   // N19
        chk_id("t4.n19", 1'b0, 32'h100, 32'h13);
        stall_if    = 1'b0;
        flush_if_id = 1'b0;
        step();                                   // N20
        chk_id("t4.n20", 1'b1, 32'h104, 32'h104);
        chk_req("t4.n20", 1'b1, 32'h108);

        // 5: move pc to 0x20, then redirect in the handshake cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        imem_req_ready = 1'b0;
        step();                                   // N21
        chk_req("t5.n21", 1'b1, 32'h20);
        imem_req_ready = 1'b1;
        redirect_pc    = 32'h40;
        step();                                   // N22: KILL
        redirect_valid = 1'b0;
        chk_req("t5.n22", 1'b0, 32'h40);
        step();                                   // N23
        chk_req("t5.n23", 1'b1, 32'h40);
        chk_id("t5.n23", 1'b1, 32'h104, 32'h104);
        step();                                   // N24
        step();                                   // N25
        chk_id("t5.n25", 1'b1, 32'h40, 32'h40);

        // 6: wrap at top of address space (low bits of target ignored)
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        imem_req_ready = 1'b0;
        step();                                   // N26
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk_req("t6.n26", 1'b1, 32'hFFFF_FFFC);
        step();                                   // N27
        step();                                   // N28
        chk_id("t6.n28", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk_req("t6.n28", 1'b1, 32'h0);
        step();                                   // N29: WAIT on 0x0
        chk_req("t6.n29", 1'b0, 32'h4);

        // asynchronous reset mid-WAIT
        rst_n = 1'b0;
        #1;
        chk_req("t6.rst", 1'b0, 32'h0);
        chk_id("t6.rst", 1'b0, 32'h0, 32'h13);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();                                   // N30
        chk_req("t6.n30", 1'b1, 32'h0);
        chk_id("t6.n30", 1'b0, 32'h0, 32'h13);
        step();                                   // N31
        step();                                   // N32
        chk_id("t6.n32", 1'b1, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
